// File: rtl/wb_sim_mem_delay_bridge_if.sv
// wb_sim_mem_delay_bridge_if: Wishbone B3 bundle; master drives adr/dat_w/sel/we/cyc/stb/cti/bte, slave drives dat_r/ack/err
interface wb_sim_mem_delay_bridge_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0] sel;
  logic we;
  logic cyc;
  logic stb;
  logic [2:0] cti;
  logic [1:0] bte;
  logic ack;
  logic err;
  modport master (output adr, dat_w, sel, we, cyc, stb, cti, bte, input dat_r, ack, err);
  modport slave (input adr, dat_w, sel, we, cyc, stb, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/wb_sim_mem_delay_bridge.sv
// wb_sim_mem_delay_bridge: wait-state/range-check bridge to sim RAM; ports wb_clk_i, wb_rst_i, wbm (from master), wbs (to RAM), beat_cnt_o (acked beats)
module wb_sim_mem_delay_bridge #(
  parameter logic [31:0] MEM_SIZE = 32'h0200_0000,
  parameter int unsigned FIRST_WAIT = 2,
  parameter int unsigned BEAT_WAIT = 0
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  wb_sim_mem_delay_bridge_if.slave wbm,
  wb_sim_mem_delay_bridge_if.master wbs,
  output logic [31:0] beat_cnt_o
);
  typedef enum logic [1:0] {IDLE, WAIT, FWD, ERR} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt, w_cnt;
  logic [31:0] r_beat_cnt;
  logic w_bad, w_fwd, w_ack;
  assign w_bad = wbm.adr >= MEM_SIZE;
  assign wbs.adr = wbm.adr;
  assign wbs.dat_w = wbm.dat_w;
  assign wbs.sel = wbm.sel;
  assign wbs.we = wbm.we;
  assign wbs.bte = wbm.bte;
  assign wbs.cti = BEAT_WAIT == 0 ? wbm.cti : 3'b000;
  assign beat_cnt_o = r_beat_cnt;
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: if (wbm.stb) begin
        w_next = w_bad ? ERR : FIRST_WAIT == 0 ? FWD : WAIT;
        w_cnt = 8'(FIRST_WAIT);
      end
      WAIT: begin
        w_next = r_cnt <= 8'd1 ? FWD : WAIT;
        w_cnt = r_cnt - 8'd1;
      end
      FWD: begin
        w_next = (wbm.stb && w_bad) ? ERR : wbs.err ? IDLE : !wbs.ack ? FWD :
                 (wbm.cti == 3'b000 || wbm.cti == 3'b111) ? IDLE :
                 (wbm.cti == 3'b010 && BEAT_WAIT > 0) ? WAIT : FWD;
        w_cnt = 8'(BEAT_WAIT);
      end
      default: w_next = IDLE;
    endcase
    if (!wbm.cyc) w_next = IDLE;
    w_fwd = !wb_rst_i && r_state == FWD && wbm.cyc && !(wbm.stb && w_bad);
    w_ack = w_fwd && wbs.ack && !wbs.err;
    wbs.cyc = w_fwd;
    wbs.stb = w_fwd && wbm.stb;
    wbm.ack = w_ack;
    wbm.err = (w_fwd && wbs.err) || (!wb_rst_i && r_state == ERR && wbm.cyc);
    wbm.dat_r = w_ack ? wbs.dat_r : '0;
  end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      if (w_ack && ~&r_beat_cnt) r_beat_cnt <= r_beat_cnt + 32'd1;
    end
endmodule

// File: tb/tb_wb_sim_mem_delay_bridge.sv
// tb_wb_sim_mem_delay_bridge: directed self-checking bench with a registered-ack sim RAM behind the bridge
module tb_wb_sim_mem_delay_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] beat_cnt;
  int checks = 0;
  int errors = 0;
  int ack_total = 0;
  int err_total = 0;
  int scyc_total = 0;
  int cti_bad = 0;
  int both_cnt = 0;
  logic [31:0] mem [256];
  wb_sim_mem_delay_bridge_if m_if ();
  wb_sim_mem_delay_bridge_if s_if ();
  wb_sim_mem_delay_bridge #(.MEM_SIZE(32'h0200_0000), .FIRST_WAIT(2), .BEAT_WAIT(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbm(m_if.slave), .wbs(s_if.master), .beat_cnt_o(beat_cnt)
  );
  always #5 clk = ~clk;
  assign s_if.err = 1'b0;
  assign s_if.dat_r = s_if.ack ? mem[s_if.adr[9:2]] : 32'h0;
  always @(posedge clk) begin
    s_if.ack <= !rst && s_if.cyc && s_if.stb && !s_if.ack;
    if (rst) begin
      mem[1] <= 32'hAABB_CCDD;
      mem[16] <= 32'h1000_0000;
      mem[17] <= 32'h1000_0001;
      mem[18] <= 32'h1000_0002;
      mem[19] <= 32'h1000_0003;
      mem[64] <= 32'hDEAD_BEEF;
    end else if (s_if.cyc && s_if.stb && !s_if.ack && s_if.we)
      for (int b = 0; b < 4; b++) if (s_if.sel[b]) mem[s_if.adr[9:2]][8*b +: 8] <= s_if.dat_w[8*b +: 8];
  end
  always @(posedge clk) begin
    if (m_if.ack) ack_total <= ack_total + 1;
    if (m_if.err) err_total <= err_total + 1;
    if (s_if.cyc) scyc_total <= scyc_total + 1;
    if (s_if.stb && s_if.cti != 3'b000) cti_bad <= cti_bad + 1;
    if (m_if.ack && m_if.err) both_cnt <= both_cnt + 1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
    m_if.adr = adr;
    m_if.we = we;
    m_if.dat_w = dat;
    m_if.sel = sel;
    m_if.cti = cti;
    m_if.bte = 2'b00;
    m_if.cyc = 1'b1;
    m_if.stb = 1'b1;
  endtask
  task automatic idle();
    m_if.cyc = 1'b0;
    m_if.stb = 1'b0;
    m_if.we = 1'b0;
    m_if.cti = 3'b000;
  endtask
  task automatic beat(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel,
                      input logic [2:0] cti, output int n, output logic [31:0] rd, output logic ack, output logic err);
    drive(adr, we, dat, sel, cti);
    n = 0;
    ack = 1'b0;
    err = 1'b0;
    rd = '0;
    while (n < 50 && !ack && !err) begin
      tick();
      n++;
      ack = m_if.ack;
      err = m_if.err;
      rd = m_if.dat_r;
    end
    tick();
  endtask
  initial begin
    int n, a0, e0, c0;
    logic [31:0] rd;
    logic ack, err;
    idle();
    m_if.adr = '0;
    m_if.dat_w = '0;
    m_if.sel = '0;
    m_if.bte = '0;
    repeat (3) tick();
    chk("rst_ack", m_if.ack, 0);
    chk("rst_err", m_if.err, 0);
    chk("rst_scyc", s_if.cyc, 0);
    chk("rst_beat", beat_cnt, 0);
    rst = 1'b0;
    tick();
    drive(32'h100, 1'b0, 32'h0, 4'hF, 3'b000);
    tick();
    tick();
    chk("t1_stb_wait", s_if.stb, 0);
    chk("t1_dat_idle", m_if.dat_r, 0);
    tick();
    chk("t1_stb_rise", s_if.stb, 1);
    tick();
    chk("t1_ack", m_if.ack, 1);
    chk("t1_data", m_if.dat_r, 32'hDEAD_BEEF);
    tick();
    idle();
    chk("t1_beat", beat_cnt, 1);
    a0 = ack_total;
    beat(32'h4, 1'b1, 32'h1234_5678, 4'b0011, 3'b000, n, rd, ack, err);
    idle();
    tick();
    tick();
    chk("t2_ack", ack, 1);
    chk("t2_err", err, 0);
    chk("t2_lat", n, 4);
    chk("t2_mem", mem[1], 32'hAABB_5678);
    chk("t2_ack_once", ack_total - a0, 1);
    chk("t2_beat", beat_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      beat(32'h40 + 32'(4 * i), 1'b0, 32'h0, 4'hF, i == 3 ? 3'b111 : 3'b010, n, rd, ack, err);
      chk($sformatf("t3_ack%0d", i), ack, 1);
      chk($sformatf("t3_dat%0d", i), rd, 32'h1000_0000 + 32'(i));
      chk($sformatf("t3_lat%0d", i), n, i == 0 ? 4 : 2);
    end
    idle();
    tick();
    chk("t3_cti", cti_bad, 0);
    chk("t3_beat", beat_cnt, 6);
    e0 = err_total;
    c0 = scyc_total;
    beat(32'h0200_0000, 1'b0, 32'h0, 4'hF, 3'b000, n, rd, ack, err);
    idle();
    chk("t4_err", err, 1);
    chk("t4_ack", ack, 0);
    chk("t4_lat", n, 1);
    tick();
    chk("t4_err_low", m_if.err, 0);
    chk("t4_err_once", err_total - e0, 1);
    chk("t4_scyc", scyc_total - c0, 0);
    chk("t4_beat", beat_cnt, 6);
    a0 = ack_total;
    drive(32'h100, 1'b0, 32'h0, 4'hF, 3'b000);
    tick();
    idle();
    tick();
    chk("t5_scyc_drop", s_if.cyc, 0);
    beat(32'h4, 1'b0, 32'h0, 4'hF, 3'b000, n, rd, ack, err);
    idle();
    tick();
    chk("t5_lat", n, 4);
    chk("t5_dat", rd, 32'hAABB_5678);
    chk("t5_no_stray", ack_total - a0, 1);
    chk("t5_beat", beat_cnt, 7);
    beat(32'h40, 1'b0, 32'h0, 4'hF, 3'b010, n, rd, ack, err);
    chk("t6_b0_ack", ack, 1);
    chk("t6_beat_pre", beat_cnt, 8);
    drive(32'h44, 1'b0, 32'h0, 4'hF, 3'b010);
    tick();
    chk("t6_fwd", s_if.cyc, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_scyc", s_if.cyc, 0);
    tick();
    chk("t6_scyc", s_if.cyc, 0);
    chk("t6_ack", m_if.ack, 0);
    chk("t6_beat", beat_cnt, 0);
    rst = 1'b0;
    idle();
    tick();
    chk("t6_idle_scyc", s_if.cyc, 0);
    beat(32'h100, 1'b0, 32'h0, 4'hF, 3'b000, n, rd, ack, err);
    idle();
    tick();
    chk("t6_post_lat", n, 4);
    chk("t6_post_dat", rd, 32'hDEAD_BEEF);
    chk("t6_post_beat", beat_cnt, 1);
    chk("ack_err_excl", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
